// File: rtl/conv1d_ctrl.sv
// conv1d_ctrl: sequencer for a 1-D convolution engine.
// Memory map: kernel words at 0..3, input samples from 20, results at 108..127.
// It loads the kernel once. For each output it then reads a window of input
// samples, lets the MAC drain, writes the result and slides the window by one.
// Every output comes straight from a flop, so downstream pointers and the
// memory see no glitches.
module conv1d_ctrl #(
    parameter int KER_TAPS = 4,
    parameter int N_OUT    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ker_tc4,
    input  logic       ker_tc20,
    input  logic       out_tc127,
    output logic       cnt_ker_en,
    output logic       cnt_ker_rst_n,
    output logic       reg_init_cnt_inp_ld,
    output logic       reg_init_cnt_inp_rst_n,
    output logic       cnt_inp_ld,
    output logic       cnt_inp_en,
    output logic       cnt_inp_rst_n,
    output logic       cnt_out_en,
    output logic       cnt_out_rst_n,
    output logic [1:0] mux_addr_sel,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic       ker_ld_en,
    output logic       mac_en,
    output logic       acc_clr,
    output logic [1:0] tap_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CLR  = 4'd1,
        S_KER  = 4'd2,
        S_KDRN = 4'd3,
        S_MAC  = 4'd4,
        S_MDRN = 4'd5,
        S_WR   = 4'd6,
        S_ADV  = 4'd7,
        S_DONE = 4'd8
    } state_t;

    // The last tap index ends both the kernel-load burst and the window burst.
    localparam logic [1:0] TAP_LAST = 2'(KER_TAPS - 1);

    localparam logic [1:0] SEL_KER  = 2'b00;
    localparam logic [1:0] SEL_INP  = 2'b01;
    localparam logic [1:0] SEL_OUT  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // ker_tc20 has no role in this sequence. The number of outputs is set by
    // the output pointer's terminal flag, not by N_OUT.
    logic unused_inputs;
    assign unused_inputs = ker_tc20 | (N_OUT == 0);

    state_t     state_q, state_d;
    logic [1:0] tap_q, tap_d;

    logic       cnt_ker_en_q, cnt_ker_en_d;
    logic       cnt_ker_rst_n_q, cnt_ker_rst_n_d;
    logic       reg_init_ld_q, reg_init_ld_d;
    logic       reg_init_rst_n_q, reg_init_rst_n_d;
    logic       cnt_inp_ld_q, cnt_inp_ld_d;
    logic       cnt_inp_en_q, cnt_inp_en_d;
    logic       cnt_inp_rst_n_q, cnt_inp_rst_n_d;
    logic       cnt_out_en_q, cnt_out_en_d;
    logic       cnt_out_rst_n_q, cnt_out_rst_n_d;
    logic [1:0] mux_addr_sel_q, mux_addr_sel_d;
    logic       mem_rd_en_q, mem_rd_en_d;
    logic       mem_wr_en_q, mem_wr_en_d;
    logic       ker_ld_en_q, ker_ld_en_d;
    logic       mac_en_q, mac_en_d;
    logic       acc_clr_q, acc_clr_d;
    logic [1:0] tap_idx_q, tap_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // Next-state, tap counter and the control word for the coming state.
    // Outputs are decoded from state_d and then registered, so each output
    // lines up with the state it belongs to.
    always_comb begin
        state_d = state_q;
        tap_d   = 2'd0;

        unique case (state_q)
            S_IDLE: if (start) state_d = S_CLR;
            S_CLR:  state_d = S_KER;
            S_KER: begin
                tap_d = tap_q + 2'd1;
                if (tap_q == TAP_LAST) state_d = S_KDRN;
            end
            S_KDRN: state_d = S_MAC;
            S_MAC: begin
                tap_d = tap_q + 2'd1;
                if (tap_q == TAP_LAST) state_d = S_MDRN;
            end
            S_MDRN: state_d = S_WR;
            S_WR:   state_d = out_tc127 ? S_DONE : S_ADV;
            S_ADV:  state_d = S_MAC;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_ker_en_d     = 1'b0;
        cnt_ker_rst_n_d  = 1'b1;
        reg_init_ld_d    = 1'b0;
        reg_init_rst_n_d = 1'b1;
        cnt_inp_ld_d     = 1'b0;
        cnt_inp_en_d     = 1'b0;
        cnt_inp_rst_n_d  = 1'b1;
        cnt_out_en_d     = 1'b0;
        cnt_out_rst_n_d  = 1'b1;
        mux_addr_sel_d   = SEL_NONE;
        mem_rd_en_d      = 1'b0;
        mem_wr_en_d      = 1'b0;
        acc_clr_d        = 1'b0;
        done_d           = 1'b0;
        busy_d           = (state_d != S_IDLE);

        unique case (state_d)
            S_CLR: begin
                cnt_ker_rst_n_d  = 1'b0;
                reg_init_rst_n_d = 1'b0;
                cnt_inp_rst_n_d  = 1'b0;
                cnt_out_rst_n_d  = 1'b0;
            end
            S_KER: begin
                mux_addr_sel_d = SEL_KER;
                mem_rd_en_d    = 1'b1;
                cnt_ker_en_d   = 1'b1;
            end
            S_KDRN: acc_clr_d = 1'b1;
            S_MAC: begin
                mux_addr_sel_d = SEL_INP;
                mem_rd_en_d    = 1'b1;
                cnt_inp_en_d   = 1'b1;
                // Capture the window start only on the first read of a window.
                reg_init_ld_d  = (state_q != S_MAC);
            end
            S_WR: begin
                mux_addr_sel_d = SEL_OUT;
                mem_wr_en_d    = 1'b1;
                cnt_out_en_d   = 1'b1;
                // Rewind the input pointer to the window start; ADV steps it.
                cnt_inp_ld_d   = 1'b1;
            end
            S_ADV: begin
                cnt_inp_en_d = 1'b1;
                acc_clr_d    = 1'b1;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase

        // Read data returns one cycle after the strobe. The datapath
        // qualifiers therefore trail the read states by one cycle.
        ker_ld_en_d = (state_q == S_KER);
        mac_en_d    = (state_q == S_MAC);
        tap_idx_d   = tap_q;

        // The kernel pointer must have reached its terminal count by the
        // drain cycle. The error flag is sticky until the next run clears it.
        if (state_d == S_CLR) begin
            err_d = 1'b0;
        end else if ((state_q == S_KDRN) && !ker_tc4) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State and registered outputs. Reset forces every output to its idle
    // value and holds all pointer resets asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            tap_q            <= 2'd0;
            cnt_ker_en_q     <= 1'b0;
            cnt_ker_rst_n_q  <= 1'b0;
            reg_init_ld_q    <= 1'b0;
            reg_init_rst_n_q <= 1'b0;
            cnt_inp_ld_q     <= 1'b0;
            cnt_inp_en_q     <= 1'b0;
            cnt_inp_rst_n_q  <= 1'b0;
            cnt_out_en_q     <= 1'b0;
            cnt_out_rst_n_q  <= 1'b0;
            mux_addr_sel_q   <= SEL_NONE;
            mem_rd_en_q      <= 1'b0;
            mem_wr_en_q      <= 1'b0;
            ker_ld_en_q      <= 1'b0;
            mac_en_q         <= 1'b0;
            acc_clr_q        <= 1'b0;
            tap_idx_q        <= 2'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            tap_q            <= tap_d;
            cnt_ker_en_q     <= cnt_ker_en_d;
            cnt_ker_rst_n_q  <= cnt_ker_rst_n_d;
            reg_init_ld_q    <= reg_init_ld_d;
            reg_init_rst_n_q <= reg_init_rst_n_d;
            cnt_inp_ld_q     <= cnt_inp_ld_d;
            cnt_inp_en_q     <= cnt_inp_en_d;
            cnt_inp_rst_n_q  <= cnt_inp_rst_n_d;
            cnt_out_en_q     <= cnt_out_en_d;
            cnt_out_rst_n_q  <= cnt_out_rst_n_d;
            mux_addr_sel_q   <= mux_addr_sel_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_wr_en_q      <= mem_wr_en_d;
            ker_ld_en_q      <= ker_ld_en_d;
            mac_en_q         <= mac_en_d;
            acc_clr_q        <= acc_clr_d;
            tap_idx_q        <= tap_idx_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_q            <= err_d;
        end
    end

    assign cnt_ker_en             = cnt_ker_en_q;
    assign cnt_ker_rst_n          = cnt_ker_rst_n_q;
    assign reg_init_cnt_inp_ld    = reg_init_ld_q;
    assign reg_init_cnt_inp_rst_n = reg_init_rst_n_q;
    assign cnt_inp_ld             = cnt_inp_ld_q;
    assign cnt_inp_en             = cnt_inp_en_q;
    assign cnt_inp_rst_n          = cnt_inp_rst_n_q;
    assign cnt_out_en             = cnt_out_en_q;
    assign cnt_out_rst_n          = cnt_out_rst_n_q;
    assign mux_addr_sel           = mux_addr_sel_q;
    assign mem_rd_en              = mem_rd_en_q;
    assign mem_wr_en              = mem_wr_en_q;
    assign ker_ld_en              = ker_ld_en_q;
    assign mac_en                 = mac_en_q;
    assign acc_clr                = acc_clr_q;
    assign tap_idx                = tap_idx_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign err                    = err_q;

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Bench for conv1d_ctrl. A behavioural model of the address pointers turns
// the DUT's pointer controls into memory addresses. Every memory strobe is
// checked against an expected access queue built from the intended memory map.
module tb_conv1d_ctrl;

    localparam int RUN_CYCLES = 145;
    localparam int WAIT_LIMIT = 400;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       ker_tc4;
    logic       ker_tc20 = 1'b0;
    logic       out_tc127;
    logic       cnt_ker_en, cnt_ker_rst_n, reg_init_cnt_inp_ld, reg_init_cnt_inp_rst_n;
    logic       cnt_inp_ld, cnt_inp_en, cnt_inp_rst_n, cnt_out_en, cnt_out_rst_n;
    logic [1:0] mux_addr_sel;
    logic       mem_rd_en, mem_wr_en, ker_ld_en, mac_en, acc_clr;
    logic [1:0] tap_idx;
    logic       busy, done, err;

    conv1d_ctrl #(.KER_TAPS(4), .N_OUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ker_tc4(ker_tc4), .ker_tc20(ker_tc20), .out_tc127(out_tc127),
        .cnt_ker_en(cnt_ker_en), .cnt_ker_rst_n(cnt_ker_rst_n),
        .reg_init_cnt_inp_ld(reg_init_cnt_inp_ld),
        .reg_init_cnt_inp_rst_n(reg_init_cnt_inp_rst_n),
        .cnt_inp_ld(cnt_inp_ld), .cnt_inp_en(cnt_inp_en), .cnt_inp_rst_n(cnt_inp_rst_n),
        .cnt_out_en(cnt_out_en), .cnt_out_rst_n(cnt_out_rst_n),
        .mux_addr_sel(mux_addr_sel), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .ker_ld_en(ker_ld_en), .mac_en(mac_en), .acc_clr(acc_clr), .tap_idx(tap_idx),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- pointer model ----------------
    logic [6:0] ker_ptr, inp_ptr, init_ptr, out_ptr;
    logic       force_tc4_low = 1'b0;

    always @(posedge clk) begin
        if (!cnt_ker_rst_n) ker_ptr <= 7'd0;
        else if (cnt_ker_en) ker_ptr <= ker_ptr + 7'd1;
        if (!reg_init_cnt_inp_rst_n) init_ptr <= 7'd20;
        else if (reg_init_cnt_inp_ld) init_ptr <= inp_ptr;
        if (!cnt_inp_rst_n) inp_ptr <= 7'd20;
        else if (cnt_inp_ld) inp_ptr <= init_ptr;
        else if (cnt_inp_en) inp_ptr <= inp_ptr + 7'd1;
        if (!cnt_out_rst_n) out_ptr <= 7'd108;
        else if (cnt_out_en) out_ptr <= out_ptr + 7'd1;
    end

    assign ker_tc4   = force_tc4_low ? 1'b0 : (ker_ptr == 7'd4);
    assign out_tc127 = (out_ptr == 7'd127);

    // ker_tc20 is noise the DUT must ignore.
    initial forever begin
        @(negedge clk);
        ker_tc20 = 1'($urandom_range(0, 1));
    end

    // ---------------- scoreboard ----------------
    // Entry: {select valid, write, address}
    logic [8:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;

    task automatic push_run_expect(input int n_outputs, input int partial_reads);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 1'b0, 7'(k)});
        for (int o = 0; o < n_outputs; o++) begin
            for (int t = 0; t < 4; t++) exp_q.push_back({1'b1, 1'b0, 7'(20 + o + t)});
            exp_q.push_back({1'b1, 1'b1, 7'(108 + o)});
        end
        for (int t = 0; t < partial_reads; t++)
            exp_q.push_back({1'b1, 1'b0, 7'(20 + n_outputs + t)});
    endtask

    always @(negedge clk) begin
        logic [8:0] obs;
        logic [8:0] exp;
        if (mem_rd_en || mem_wr_en) begin
            case (mux_addr_sel)
                2'b00:   obs = {1'b1, mem_wr_en, ker_ptr};
                2'b01:   obs = {1'b1, mem_wr_en, inp_ptr};
                2'b10:   obs = {1'b1, mem_wr_en, out_ptr};
                default: obs = {1'b0, mem_wr_en, 7'h00};
            endcase
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mem_access: got %h, expected no access at %0t", obs, $time);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL mem_access: got %h, expected %h at %0t", obs, exp, $time);
                end
            end
            n_vec++;
            if (mem_rd_en && mem_wr_en) begin
                n_err++;
                $display("FAIL rd_wr_overlap: got rd=1 wr=1, expected exclusive at %0t", $time);
            end
        end
        if (mem_wr_en) begin
            n_wr++;
            n_vec++;
            if ({cnt_inp_ld, cnt_inp_en} !== 2'b10) begin
                n_err++;
                $display("FAIL wr_inp_ctl: got ld,en=%b, expected 10 at %0t",
                         {cnt_inp_ld, cnt_inp_en}, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [12:0] ctl_vec();
        return {cnt_ker_en, reg_init_cnt_inp_ld, cnt_inp_ld, cnt_inp_en, cnt_out_en,
                mem_rd_en, mem_wr_en, ker_ld_en, mac_en, acc_clr, done, busy, err};
    endfunction

    function automatic logic [3:0] rstn_vec();
        return {cnt_ker_rst_n, reg_init_cnt_inp_rst_n, cnt_inp_rst_n, cnt_out_rst_n};
    endfunction

    // Returns at the negedge of the CLR cycle (cycle 0 of the run).
    task automatic drive_start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (done !== 1'b1 && c < WAIT_LIMIT) begin
            @(negedge clk);
            c++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (ctl_vec() !== 13'd0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b, expected 0", ctl_vec());
        end
        n_vec++;
        if ({rstn_vec(), mux_addr_sel, tap_idx} !== 8'b0000_11_00) begin
            n_err++;
            $display("FAIL reset_rstn_sel_tap: got %b, expected 00001100",
                     {rstn_vec(), mux_addr_sel, tap_idx});
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (rstn_vec() !== 4'h0) begin
            n_err++;
            $display("FAIL rstn_before_edge: got %b, expected 0000", rstn_vec());
        end
        @(negedge clk);
        n_vec++;
        if ({rstn_vec(), busy, mux_addr_sel} !== 7'b1111_0_11) begin
            n_err++;
            $display("FAIL rstn_after_edge: got %b, expected 1111011",
                     {rstn_vec(), busy, mux_addr_sel});
        end
    endtask

    task automatic test_kernel_phase();
        int c;
        logic [5:0] exp_ctl;
        logic [1:0] exp_tap;
        push_run_expect(20, 0);
        drive_start_pulse();
        n_vec++;
        if ({rstn_vec(), busy, mem_rd_en, mux_addr_sel} !== 8'b0000_1_0_11) begin
            n_err++;
            $display("FAIL clr_cycle: got %b, expected 00001011",
                     {rstn_vec(), busy, mem_rd_en, mux_addr_sel});
        end
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            // {rd, ker_en, ker_ld, acc_clr, init_ld, mac_en}
            exp_ctl = {(n <= 4) || (n >= 6), n <= 4, (n >= 2) && (n <= 5),
                       n == 5, n == 6, n == 7};
            exp_tap = ((n >= 2) && (n <= 5)) ? 2'(n - 2) : 2'd0;
            n_vec++;
            if ({mem_rd_en, cnt_ker_en, ker_ld_en, acc_clr, reg_init_cnt_inp_ld, mac_en,
                 tap_idx} !== {exp_ctl, exp_tap}) begin
                n_err++;
                $display("FAIL kernel_cycle%0d: got %b, expected %b", n,
                         {mem_rd_en, cnt_ker_en, ker_ld_en, acc_clr, reg_init_cnt_inp_ld,
                          mac_en, tap_idx}, {exp_ctl, exp_tap});
            end
            if (n != 5) begin
                n_vec++;
                if (mux_addr_sel !== ((n <= 4) ? 2'b00 : 2'b01)) begin
                    n_err++;
                    $display("FAIL kernel_sel%0d: got %b, expected %b", n, mux_addr_sel,
                             (n <= 4) ? 2'b00 : 2'b01);
                end
            end
        end
        wait_done(7, c);
        n_vec++;
        if (c !== RUN_CYCLES) begin
            n_err++;
            $display("FAIL run_length: got %0d, expected %0d", c, RUN_CYCLES);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, done, err} !== 3'b000) begin
            n_err++;
            $display("FAIL after_done: got busy,done,err=%b, expected 000", {busy, done, err});
        end
    endtask

    task automatic test_full_run();
        int c;
        int wr0;
        wr0 = n_wr;
        push_run_expect(20, 0);
        drive_start_pulse();
        c = 0;
        // Stray start pulses mid-run must be ignored.
        while (done !== 1'b1 && c < WAIT_LIMIT) begin
            start = (c >= 2 && c <= 139) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        n_vec++;
        if (c !== RUN_CYCLES) begin
            n_err++;
            $display("FAIL full_run_length: got %0d, expected %0d", c, RUN_CYCLES);
        end
        n_vec++;
        if (n_wr - wr0 !== 20) begin
            n_err++;
            $display("FAIL full_run_writes: got %0d, expected 20", n_wr - wr0);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, mem_rd_en, exp_q.size() == 0} !== 3'b001) begin
            n_err++;
            $display("FAIL full_run_idle: got busy,rd,qempty=%b, expected 001",
                     {busy, mem_rd_en, exp_q.size() == 0});
        end
    endtask

    task automatic test_err();
        int c;
        bit err_dropped;
        push_run_expect(20, 0);
        force_tc4_low = 1'b1;
        drive_start_pulse();
        repeat (5) @(negedge clk);
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_in_kdrn: got %b, expected 0", err);
        end
        @(negedge clk);
        force_tc4_low = 1'b0;
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: got %b, expected 1", err);
        end
        c = 6;
        err_dropped = 1'b0;
        while (done !== 1'b1 && c < WAIT_LIMIT) begin
            @(negedge clk);
            c++;
            if (err !== 1'b1) err_dropped = 1'b1;
        end
        n_vec++;
        if ({err_dropped, c == RUN_CYCLES} !== 2'b01) begin
            n_err++;
            $display("FAIL err_held: got dropped=%b len=%0d, expected 0 and %0d",
                     err_dropped, c, RUN_CYCLES);
        end
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_idle: got %b, expected 1", err);
        end
        push_run_expect(20, 0);
        drive_start_pulse();
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: got %b, expected 0", err);
        end
        wait_done(0, c);
        n_vec++;
        if ({err, c == RUN_CYCLES} !== 2'b01) begin
            n_err++;
            $display("FAIL err_clean_run: got err=%b len=%0d, expected 0 and %0d",
                     err, c, RUN_CYCLES);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c;
        push_run_expect(20, 0);
        push_run_expect(20, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(0, c);
        n_vec++;
        if (c !== RUN_CYCLES) begin
            n_err++;
            $display("FAIL b2b_first_length: got %0d, expected %0d", c, RUN_CYCLES);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got busy=%b, expected 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({busy, rstn_vec()} !== 5'b1_0000) begin
            n_err++;
            $display("FAIL b2b_restart: got %b, expected 10000", {busy, rstn_vec()});
        end
        wait_done(0, c);
        n_vec++;
        if (c !== RUN_CYCLES) begin
            n_err++;
            $display("FAIL b2b_second_length: got %0d, expected %0d", c, RUN_CYCLES);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, exp_q.size() == 0} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_end: got busy,qempty=%b, expected 01", {busy, exp_q.size() == 0});
        end
    endtask

    task automatic test_abort();
        int c;
        int wr0;
        wr0 = n_wr;
        // Fifth output: its first two reads happen before reset hits.
        push_run_expect(4, 2);
        drive_start_pulse();
        repeat (35) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ctl_vec() !== 13'd0) begin
            n_err++;
            $display("FAIL abort_ctl: got %b, expected 0", ctl_vec());
        end
        n_vec++;
        if ({rstn_vec(), mux_addr_sel, tap_idx} !== 8'b0000_11_00) begin
            n_err++;
            $display("FAIL abort_rstn_sel_tap: got %b, expected 00001100",
                     {rstn_vec(), mux_addr_sel, tap_idx});
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({n_wr - wr0 == 4, exp_q.size() == 0} !== 2'b11) begin
            n_err++;
            $display("FAIL abort_accesses: got writes=%0d left=%0d, expected 4 and 0",
                     n_wr - wr0, exp_q.size());
        end
        rst_n = 1'b1;
        @(negedge clk);
        push_run_expect(20, 0);
        drive_start_pulse();
        wait_done(0, c);
        n_vec++;
        if (c !== RUN_CYCLES) begin
            n_err++;
            $display("FAIL abort_restart_length: got %0d, expected %0d", c, RUN_CYCLES);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, err, exp_q.size() == 0} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_restart_end: got busy,err,qempty=%b, expected 001",
                     {busy, err, exp_q.size() == 0});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_kernel_phase();
        test_full_run();
        test_err();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected sequence to finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv1d_ctrl.md
CONV1D_CTRL -- requirements
Module: conv1d_ctrl

Interface
REQ-001 SHALL have parameter KER_TAPS, default 4, meaning kernel length in words; only 4 is supported.
REQ-002 SHALL have parameter N_OUT, default 20, meaning outputs per run (addresses 108..127).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, run request, sampled in IDLE only.
REQ-006 SHALL have port ker_tc4, input, 1, registered kernel-counter terminal flag from the address pointer.
REQ-007 SHALL have port ker_tc20, input, 1, unused and ignored.
REQ-008 SHALL have port out_tc127, input, 1, registered output-counter terminal flag.
REQ-009 SHALL have ports cnt_ker_en, cnt_ker_rst_n, reg_init_cnt_inp_ld, reg_init_cnt_inp_rst_n, cnt_inp_ld, cnt_inp_en, cnt_inp_rst_n, cnt_out_en, cnt_out_rst_n, each output, 1, pointer controls.
REQ-010 SHALL have port mux_addr_sel, output, 2, address select: 00 kernel, 01 input, 10 output.
REQ-011 SHALL have ports mem_rd_en and mem_wr_en, output, 1, memory strobes; read data valid 1 cycle after mem_rd_en.
REQ-012 SHALL have ports ker_ld_en (1), mac_en (1), acc_clr (1) and tap_idx (2), outputs, datapath controls aligned to returning read data.
REQ-013 SHALL have ports busy, done and err, outputs, 1 each, status.

Function
REQ-014 SHALL implement states IDLE, CLR, KER, KDRN, MAC, MDRN, WR, ADV, DONE; every output is driven from a register (glitch-free).
REQ-015 SHALL move from IDLE to CLR when start=1; start is ignored in all other states.
REQ-016 CLR (1 cycle): all four *_rst_n outputs SHALL be 0; they are 1 in every other state.
REQ-017 KER (4 cycles, internal 2-bit tap counter 0..3): mux_addr_sel=00, mem_rd_en=1, cnt_ker_en=1; then KDRN.
REQ-018 KDRN (1 cycle): acc_clr=1; err SHALL be set sticky if ker_tc4=0; then MAC.
REQ-019 MAC (4 cycles): mux_addr_sel=01, mem_rd_en=1, cnt_inp_en=1; reg_init_cnt_inp_ld=1 in the first MAC cycle only, capturing the window start; then MDRN.
REQ-020 MDRN (1 cycle): no reads; then WR.
REQ-021 ker_ld_en and mac_en SHALL equal the previous cycle's (state==KER) and (state==MAC); tap_idx SHALL equal the previous cycle's tap counter.
REQ-022 WR (1 cycle): mux_addr_sel=10, mem_wr_en=1, cnt_out_en=1, cnt_inp_ld=1; next state DONE if out_tc127=1, else ADV.
REQ-023 ADV (1 cycle): cnt_inp_en=1 (window start+1), acc_clr=1; then MAC.
REQ-024 DONE (1 cycle): done=1; then IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 mux_addr_sel SHALL be 11 in IDLE, CLR and DONE; unlisted enables and strobes SHALL be 0.
REQ-027 Run length from the start sample to DONE entry SHALL be 145 cycles (CLR 1 + KER 4 + KDRN 1 + 19x7 + 6).
REQ-028 err SHALL clear only in CLR or on reset.

Reset
REQ-029 While rst_n=0: state IDLE; all enables, strobes, ker_ld_en, mac_en, acc_clr, done, busy, err = 0; tap_idx=00; mux_addr_sel=11; all *_rst_n outputs = 0.
REQ-030 After rst_n deasserts, *_rst_n outputs SHALL go to 1 on the first clock edge.
REQ-031 rst_n asserted mid-run SHALL abort immediately to the REQ-029 values, with no further memory strobes.

Verification
REQ-032 Reset then start pulse -> CLR 1 cycle with all four *_rst_n=0, then 4 cycles of mem_rd_en with mux_addr_sel=00, and ker_ld_en high 4 cycles with tap_idx 0,1,2,3.
REQ-033 Full run with the real pointer -> read addresses 0..3, then windows 20..23, 21..24, ..., 39..42; 20 writes to 108..127; done pulses 145 cycles after start; busy=0 after.
REQ-034 Force ker_tc4=0 during KDRN -> err=1 and held through DONE; next start clears it in CLR.
REQ-035 Hold start=1 through an entire run -> a second run begins on the cycle after DONE returns to IDLE; start pulses mid-run have no effect.
REQ-036 Assert rst_n=0 in the third MAC cycle of output 5 -> outputs match REQ-029 immediately; no mem_wr_en occurs; a restart completes normally.
REQ-037 Check mem_rd_en and mem_wr_en never assert in the same cycle, and each WR cycle has cnt_inp_ld=1 with cnt_inp_en=0.
